l2_req_scheduler: RTL and testbench

L2_REQ_SCHEDULER -- requirements
Module: l2_req_scheduler

---
 rtl/l2_req_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_l2_req_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_scheduler.sv
// l2_req_scheduler
//   Merges the L1 requesters onto one L2 request port and routes L2 read
//   responses back to the requester that issued them.
//   Each requester owns a 2-entry FIFO. A single output register feeds L2 and
//   is refilled round-robin from the non-empty FIFOs. Reads are counted per
//   requester so that no more than MAX_OUTST reads can be outstanding.
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/rw/addr/data/id  per-requester request inputs (packed)
//   req_stall                  per-requester back-pressure
//   resp_valid/data/id         per-requester registered response outputs
//   l2_valid_o/rw_o/addr_o/data_o/id_o, l2_stall_i   request port to L2
//   l2_valid_i/data_i/id_i     read responses from L2
//   err_o                      sticky: response with no matching outstanding read
module l2_req_scheduler #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 256,
  parameter int MSHR_ID_BITS = 3,
  parameter int NUM_REQ      = 2,
  parameter int NUM_REQ_LOG  = 1,
  parameter int MAX_OUTST    = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ*LINE_WIDTH-1:0]       req_data,
  input  logic [NUM_REQ*MSHR_ID_BITS-1:0]     req_id,
  output logic [NUM_REQ-1:0]                  req_stall,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [NUM_REQ*LINE_WIDTH-1:0]       resp_data,
  output logic [NUM_REQ*MSHR_ID_BITS-1:0]     resp_id,
  output logic                                l2_valid_o,
  output logic                                l2_rw_o,
  output logic [ADDR_WIDTH-1:0]               l2_addr_o,
  output logic [LINE_WIDTH-1:0]               l2_data_o,
  output logic [NUM_REQ_LOG+MSHR_ID_BITS-1:0] l2_id_o,
  input  logic                                l2_stall_i,
  input  logic                                l2_valid_i,
  input  logic [LINE_WIDTH-1:0]               l2_data_i,
  input  logic [NUM_REQ_LOG+MSHR_ID_BITS-1:0] l2_id_i,
  output logic                                err_o
);

  localparam int IDW = NUM_REQ_LOG + MSHR_ID_BITS;
  localparam int OW  = $clog2(MAX_OUTST + 1);

  logic                    fifo_rw_q   [NUM_REQ][2];
  logic [ADDR_WIDTH-1:0]   fifo_addr_q [NUM_REQ][2];
  logic [LINE_WIDTH-1:0]   fifo_data_q [NUM_REQ][2];
  logic [MSHR_ID_BITS-1:0] fifo_id_q   [NUM_REQ][2];
  logic                    wptr_q      [NUM_REQ];
  logic                    rptr_q      [NUM_REQ];
  logic [1:0]              cnt_q       [NUM_REQ];
  logic [OW-1:0]           outst_q     [NUM_REQ];

  logic                    l2_valid_q, l2_rw_q;
  logic [ADDR_WIDTH-1:0]   l2_addr_q;
  logic [LINE_WIDTH-1:0]   l2_data_q;
  logic [IDW-1:0]          l2_id_q;
  logic [NUM_REQ_LOG-1:0]  last_q;

  logic [NUM_REQ-1:0]              resp_valid_q;
  logic [NUM_REQ*LINE_WIDTH-1:0]   resp_data_q;
  logic [NUM_REQ*MSHR_ID_BITS-1:0] resp_id_q;
  logic                            err_q;

  logic [NUM_REQ-1:0]     nonempty, push, pop, rsp_hit;
  logic                   load, found, found_hi, found_lo, rsp_err;
  logic [NUM_REQ_LOG-1:0] win, win_hi, win_lo, rsp_k;

  // Stall depends only on registered FIFO occupancy and outstanding count.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      nonempty[i]  = (cnt_q[i] != 2'd0);
      req_stall[i] = (cnt_q[i] == 2'd2) || (outst_q[i] == OW'(MAX_OUTST));
      push[i]      = req_valid[i] && !req_stall[i];
    end
  end

  // Round-robin: prefer the lowest index above last grant, otherwise wrap to
  // the lowest index at or below it. Descending scan keeps the lowest match.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (nonempty[j] && (NUM_REQ_LOG'(j) > last_q)) begin
        found_hi = 1'b1;
        win_hi   = NUM_REQ_LOG'(j);
      end
      if (nonempty[j] && (NUM_REQ_LOG'(j) <= last_q)) begin
        found_lo = 1'b1;
        win_lo   = NUM_REQ_LOG'(j);
      end
    end
    found = found_hi || found_lo;
    win   = found_hi ? win_hi : win_lo;
    load  = !l2_valid_q || !l2_stall_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = load && found && (win == NUM_REQ_LOG'(i));
    end
  end

  // A response is accepted only if its requester exists and has a read pending.
  always_comb begin
    rsp_k = l2_id_i[IDW-1 -: NUM_REQ_LOG];
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_hit[i] = l2_valid_i && (rsp_k == NUM_REQ_LOG'(i)) && (outst_q[i] != '0);
    end
    rsp_err = l2_valid_i && (rsp_hit == '0);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (push[i]) begin
        fifo_rw_q[i][wptr_q[i]]   <= req_rw[i];
        fifo_addr_q[i][wptr_q[i]] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        fifo_data_q[i][wptr_q[i]] <= req_data[i*LINE_WIDTH +: LINE_WIDTH];
        fifo_id_q[i][wptr_q[i]]   <= req_id[i*MSHR_ID_BITS +: MSHR_ID_BITS];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wptr_q[i]  <= 1'b0;
        rptr_q[i]  <= 1'b0;
        cnt_q[i]   <= 2'd0;
        outst_q[i] <= '0;
      end
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (push[i]) wptr_q[i] <= !wptr_q[i];
        if (pop[i])  rptr_q[i] <= !rptr_q[i];
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 2'd1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 2'd1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
        case ({push[i] && !req_rw[i], rsp_hit[i]})
          2'b10:   outst_q[i] <= outst_q[i] + OW'(1);
          2'b01:   outst_q[i] <= outst_q[i] - OW'(1);
          default: outst_q[i] <= outst_q[i];
        endcase
        resp_valid_q[i] <= rsp_hit[i];
        if (rsp_hit[i]) begin
          resp_data_q[i*LINE_WIDTH +: LINE_WIDTH]     <= l2_data_i;
          resp_id_q[i*MSHR_ID_BITS +: MSHR_ID_BITS]   <= l2_id_i[MSHR_ID_BITS-1:0];
        end
      end
      if (rsp_err) err_q <= 1'b1;
    end
  end

  // Output register: refilled whenever empty or draining this cycle; when no
  // FIFO has an entry only the valid bit drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l2_valid_q <= 1'b0;
      l2_rw_q    <= 1'b0;
      l2_addr_q  <= '0;
      l2_data_q  <= '0;
      l2_id_q    <= '0;
      last_q     <= NUM_REQ_LOG'(NUM_REQ - 1);
    end else if (load) begin
      l2_valid_q <= found;
      if (found) begin
        l2_rw_q   <= fifo_rw_q[win][rptr_q[win]];
        l2_addr_q <= fifo_addr_q[win][rptr_q[win]];
        l2_data_q <= fifo_data_q[win][rptr_q[win]];
        l2_id_q   <= {win, fifo_id_q[win][rptr_q[win]]};
        last_q    <= win;
      end
    end
  end

  assign l2_valid_o = l2_valid_q;
  assign l2_rw_o    = l2_rw_q;
  assign l2_addr_o  = l2_addr_q;
  assign l2_data_o  = l2_data_q;
  assign l2_id_o    = l2_id_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_l2_req_scheduler.sv
module tb_l2_req_scheduler;
  localparam int MO = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_rw;
  logic [63:0]  req_addr;
  logic [511:0] req_data;
  logic [5:0]   req_id;
  logic [1:0]   req_stall, resp_valid;
  logic [511:0] resp_data;
  logic [5:0]   resp_id;
  logic         l2_valid_o, l2_rw_o;
  logic [31:0]  l2_addr_o;
  logic [255:0] l2_data_o;
  logic [3:0]   l2_id_o;
  logic         l2_stall_i, l2_valid_i;
  logic [255:0] l2_data_i;
  logic [3:0]   l2_id_i;
  logic         err_o;

  l2_req_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data), .req_id(req_id), .req_stall(req_stall),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id),
    .l2_valid_o(l2_valid_o), .l2_rw_o(l2_rw_o), .l2_addr_o(l2_addr_o),
    .l2_data_o(l2_data_o), .l2_id_o(l2_id_o), .l2_stall_i(l2_stall_i),
    .l2_valid_i(l2_valid_i), .l2_data_i(l2_data_i), .l2_id_i(l2_id_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transaction-level model: queues per requester, one output slot,
  // outstanding-read counters, round-robin pointer.
  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [2:0]   id;
  } ent_t;

  ent_t         mq [2][$];
  bit           m_ov = 0;
  logic         m_rw = 0;
  logic [31:0]  m_addr = 0;
  logic [255:0] m_data = 0;
  logic [3:0]   m_id = 0;
  int           m_lg = 1;
  int           m_outs [2] = '{0, 0};
  bit           m_rv [2] = '{0, 0};
  logic [255:0] m_rdata [2];
  logic [2:0]   m_rid [2];
  bit           m_err = 0;

  function automatic bit m_st(int i);
    return (mq[i].size() == 2) || (m_outs[i] == MO);
  endfunction

  bit   s_push [2];
  bit   s_dec [2];
  bit   s_found;
  int   s_j, s_k;
  ent_t s_e;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq[0].delete();
      mq[1].delete();
      m_ov = 0; m_rw = 0; m_addr = 0; m_data = 0; m_id = 0;
      m_lg = 1;
      m_outs[0] = 0; m_outs[1] = 0;
      m_rv[0] = 0; m_rv[1] = 0;
      m_err = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        s_push[i] = req_valid[i] && !m_st(i);
        s_dec[i]  = 0;
      end
      if (!m_ov || !l2_stall_i) begin
        s_found = 0;
        for (int s = 1; s <= 2; s++) begin
          s_j = (m_lg + s) % 2;
          if (!s_found && mq[s_j].size() > 0) begin
            s_e    = mq[s_j].pop_front();
            m_rw   = s_e.rw;
            m_addr = s_e.addr;
            m_data = s_e.data;
            m_id   = {s_j[0], s_e.id};
            m_lg   = s_j;
            s_found = 1;
          end
        end
        m_ov = s_found;
      end
      m_rv[0] = 0; m_rv[1] = 0;
      if (l2_valid_i) begin
        s_k = int'(l2_id_i[3]);
        if (s_k < 2 && m_outs[s_k] > 0) begin
          m_rv[s_k]    = 1;
          m_rdata[s_k] = l2_data_i;
          m_rid[s_k]   = l2_id_i[2:0];
          s_dec[s_k]   = 1;
        end else begin
          m_err = 1;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (s_push[i]) begin
          s_e.rw   = req_rw[i];
          s_e.addr = req_addr[i*32 +: 32];
          s_e.data = req_data[i*256 +: 256];
          s_e.id   = req_id[i*3 +: 3];
          mq[i].push_back(s_e);
          if (!req_rw[i]) m_outs[i]++;
        end
        if (s_dec[i]) m_outs[i]--;
      end
    end
  end

  always @(negedge clk) begin
    chk("req_stall", req_stall, {m_st(1), m_st(0)});
    chk("l2_valid", l2_valid_o, m_ov);
    if (m_ov) begin
      chk("l2_rw", l2_rw_o, m_rw);
      chk("l2_addr", l2_addr_o, m_addr);
      chk("l2_data", l2_data_o, m_data);
      chk("l2_id", l2_id_o, m_id);
    end
    chk("resp_valid", resp_valid, {m_rv[1], m_rv[0]});
    for (int i = 0; i < 2; i++) begin
      if (m_rv[i]) begin
        chk("resp_data", resp_data[i*256 +: 256], m_rdata[i]);
        chk("resp_id", resp_id[i*3 +: 3], m_rid[i]);
      end
    end
    chk("err", err_o, m_err);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0; req_id = '0;
    l2_valid_i = 1'b0; l2_data_i = '0; l2_id_i = '0; l2_stall_i = 1'b0;
  endtask

  task automatic put(int i, logic rw, logic [31:0] a, logic [2:0] id);
    req_valid[i]          = 1'b1;
    req_rw[i]             = rw;
    req_addr[i*32 +: 32]  = a;
    req_data[i*256 +: 256] = {8{a ^ {29'd0, id}}};
    req_id[i*3 +: 3]      = id;
  endtask

  task automatic rsp(logic [3:0] id, logic [255:0] d);
    l2_valid_i = 1'b1;
    l2_id_i    = id;
    l2_data_i  = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    cyc();
    chk("rst_l2_valid", l2_valid_o, 0);
    chk("rst_l2_addr", l2_addr_o, 0);
    chk("rst_l2_id", l2_id_o, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_req_stall", req_stall, 0);
    chk("rst_err", err_o, 0);
    cyc();
    reset = 1'b1;

    // single read, response routed back
    put(0, 1'b0, 32'h100, 3'd3);
    cyc();
    req_valid = '0;
    chk("s1_lat_not_yet", l2_valid_o, 0);
    cyc();
    chk("s1_valid", l2_valid_o, 1);
    chk("s1_id", l2_id_o, 4'b0011);
    chk("s1_addr", l2_addr_o, 32'h100);
    rsp(4'b0011, 256'hABCD_0123);
    cyc();
    l2_valid_i = 1'b0;
    chk("s1_resp_valid", resp_valid, 2'b01);
    chk("s1_resp_id", resp_id[2:0], 3'd3);
    chk("s1_resp_data", resp_data[255:0], 256'hABCD_0123);
    chk("s1_drained", l2_valid_o, 0);
    cyc();
    chk("s1_resp_pulse", resp_valid, 2'b00);
    chk("s1_no_stall", req_stall, 2'b00);

    // both requesters streaming reads: alternating grants, one per cycle
    do_reset();
    for (int c = 0; c < 9; c++) begin
      put(0, 1'b0, 32'h200 + c, 3'(c));
      put(1, 1'b0, 32'h300 + c, 3'(c));
      cyc();
      if (c >= 1) chk("s2_grant", {l2_valid_o, l2_id_o[3]}, {1'b1, ((c + 1) % 2) == 1});
    end
    idle();
    chk("s2_outst_full", req_stall, 2'b11);

    // L2 back-pressure with both FIFOs filling
    do_reset();
    l2_stall_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      put(0, 1'b0, 32'h400 + c, 3'(c));
      put(1, 1'b0, 32'h500 + c, 3'(c));
      cyc();
      if (c >= 1) chk("s3_hold_addr", l2_addr_o, 32'h400);
      if (c >= 1) chk("s3_hold_id", l2_id_o, 4'b0000);
      if (c >= 2) chk("s3_stall", req_stall, 2'b11);
    end
    req_valid = '0;
    l2_stall_i = 1'b0;
    cyc();
    chk("s3_next", l2_addr_o, 32'h500);
    for (int c = 0; c < 5; c++) cyc();

    // outstanding-read limit on requester 1; writes not counted
    do_reset();
    for (int c = 0; c < 4; c++) begin
      put(1, 1'b0, 32'h600 + c, 3'(c));
      cyc();
    end
    req_valid = '0;
    chk("s4_limit", req_stall, 2'b10);
    rsp(4'b1000, 256'h66);
    cyc();
    l2_valid_i = 1'b0;
    chk("s4_resp", resp_valid, 2'b10);
    chk("s4_released", req_stall, 2'b00);
    put(1, 1'b1, 32'h6F0, 3'd0);
    cyc();
    req_valid = '0;
    chk("s4_write_free", req_stall, 2'b00);
    put(1, 1'b0, 32'h6F1, 3'd5);
    cyc();
    req_valid = '0;
    chk("s4_limit_again", req_stall, 2'b10);
    cyc();

    // response with nothing outstanding
    do_reset();
    rsp(4'b1010, 256'h77);
    cyc();
    l2_valid_i = 1'b0;
    chk("s5_dropped", resp_valid, 2'b00);
    chk("s5_err", err_o, 1);
    cyc();
    cyc();
    chk("s5_sticky", err_o, 1);

    // reset mid-operation
    do_reset();
    l2_stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      put(0, 1'b0, 32'h800 + c, 3'(c));
      cyc();
    end
    req_valid = '0;
    chk("s6_busy", {l2_valid_o, req_stall}, 3'b101);
    #1;
    reset = 1'b0;
    #1;
    chk("s6_async_valid", l2_valid_o, 0);
    chk("s6_async_addr", l2_addr_o, 0);
    chk("s6_async_data", l2_data_o, 0);
    chk("s6_async_stall", req_stall, 0);
    chk("s6_async_err", err_o, 0);
    cyc();
    reset = 1'b1;
    l2_stall_i = 1'b0;
    rsp(4'b0001, 256'h88);
    cyc();
    l2_valid_i = 1'b0;
    chk("s6_stale_err", err_o, 1);
    chk("s6_stale_drop", resp_valid, 2'b00);
    put(0, 1'b0, 32'h900, 3'd6);
    cyc();
    req_valid = '0;
    chk("s6_not_yet", l2_valid_o, 0);
    cyc();
    chk("s6_new_valid", l2_valid_o, 1);
    chk("s6_new_addr", l2_addr_o, 32'h900);
    chk("s6_new_id", l2_id_o, 4'b0110);
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
